seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed 7-segment display driver for DIGITS hex/BCD digits sharing one segment bus. It is the successor to the two-digit display path. It adds:
- a refresh prescaler and a scan counter;
- anti-ghost blanking at each digit switch;
- leading-zero suppression;
- a load/ready handshake, so new values only appear at a frame boundary and never tear mid-scan.

It sits between the arithmetic/datapath blocks and the board display pins.

---
 rtl/seg7_scan_if.sv | 25 ++
 rtl/seg7_scan_driver.sv | 147 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_scan_if : load/ready handshake carrying a DIGITS-nibble display value
// Rev 1.0
// ---------------------------------------------------------------------------
interface seg7_scan_if #(
  parameter int DIGITS = 4
) ();
  logic [4*DIGITS-1:0] data;
  logic                load;
  logic                ready;

  modport master (
    output data,
    output load,
    input  ready
  );

  modport slave (
    input  data,
    input  load,
    output ready
  );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_scan_driver : multiplexed 7-segment scanner with blanking, leading-zero
// suppression and frame-aligned commit of new values.   Rev 1.0
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 2
) (
  input  logic              clk,
  input  logic              nRST,
  seg7_scan_if.slave        bus,
  input  logic              nEN,
  input  logic              lzs,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] digit_n,
  output logic              frame
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] C_CNT_MAX = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] C_BLANK   = CW'(BLANK);
  localparam logic [DW-1:0] C_DIG_MAX = DW'(DIGITS - 1);

  logic [CW-1:0]          r_cnt;
  logic [DW-1:0]          r_dig;
  logic [4*DIGITS-1:0]    r_act;
  logic [4*DIGITS-1:0]    r_pend;
  logic                   r_ready;
  logic [6:0]             r_seg;
  logic [DIGITS-1:0]      r_digit_n;
  logic                   r_frame;

  logic                   w_slot_tick;
  logic                   w_frame_tick;
  logic                   w_accept;
  logic                   w_commit;
  logic [3:0]             w_nib;
  logic                   w_run;
  logic                   w_lead_zero;
  logic                   w_suppress;
  logic                   w_drive;
  logic [6:0]             w_seg;
  logic [DIGITS-1:0]      w_digit_n;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] v;
    case (nib)
      4'h0:    v = 7'h3F;
      4'h1:    v = 7'h06;
      4'h2:    v = 7'h5B;
      4'h3:    v = 7'h4F;
      4'h4:    v = 7'h66;
      4'h5:    v = 7'h6D;
      4'h6:    v = 7'h7D;
      4'h7:    v = 7'h07;
      4'h8:    v = 7'h7F;
      4'h9:    v = 7'h6F;
      4'hA:    v = 7'h77;
      4'hB:    v = 7'h7C;
      4'hC:    v = 7'h39;
      4'hD:    v = 7'h5E;
      4'hE:    v = 7'h79;
      default: v = 7'h71;
    endcase
    return v;
  endfunction

  assign w_slot_tick  = (r_cnt == C_CNT_MAX);
  assign w_frame_tick = w_slot_tick && (r_dig == C_DIG_MAX);
  assign w_accept     = bus.load && r_ready;
  // Accept and commit are exclusive on ready, so a load on the frame tick
  // lands in the pending buffer only.
  assign w_commit     = w_frame_tick && !r_ready;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_cnt <= '0;
      r_dig <= '0;
    end else if (w_slot_tick) begin
      r_cnt <= '0;
      r_dig <= (r_dig == C_DIG_MAX) ? '0 : r_dig + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_pend  <= '0;
      r_act   <= '0;
      r_ready <= 1'b1;
    end else if (w_accept) begin
      r_pend  <= bus.data;
      r_ready <= 1'b0;
    end else if (w_commit) begin
      r_act   <= r_pend;
      r_ready <= 1'b1;
    end
  end

  // Walk from the most significant nibble down so w_run tells whether every
  // nibble at or above the current position is zero.
  always_comb begin
    w_nib       = 4'h0;
    w_run       = 1'b1;
    w_lead_zero = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_run = w_run && (r_act[4*i +: 4] == 4'h0);
      if (r_dig == DW'(i)) begin
        w_nib       = r_act[4*i +: 4];
        w_lead_zero = w_run;
      end
    end
  end

  always_comb begin
    w_suppress = lzs && (r_dig != '0) && w_lead_zero;
    w_drive    = !nEN && (r_cnt >= C_BLANK) && !w_suppress;
    w_digit_n  = '1;
    if (w_drive) begin
      w_digit_n[r_dig] = 1'b0;
    end
    w_seg = w_drive ? f_decode(w_nib) : 7'h00;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_seg     <= 7'h00;
      r_digit_n <= '1;
      r_frame   <= 1'b0;
    end else begin
      r_seg     <= w_seg;
      r_digit_n <= w_digit_n;
      r_frame   <= w_frame_tick;
    end
  end

  assign seg       = r_seg;
  assign digit_n   = r_digit_n;
  assign frame     = r_frame;
  assign bus.ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver : vector table plus scoreboard for DIGITS=4,
// PRESCALE=4, BLANK=1.   Rev 1.0
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 4;
  localparam int BLANK    = 1;

  logic       clk  = 1'b0;
  logic       nRST = 1'b1;
  logic       nEN  = 1'b0;
  logic       lzs  = 1'b0;
  logic [6:0] seg;
  logic [3:0] digit_n;
  logic       frame;

  seg7_scan_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan_driver #(
    .DIGITS   (DIGITS),
    .PRESCALE (PRESCALE),
    .BLANK    (BLANK)
  ) dut (
    .clk     (clk),
    .nRST    (nRST),
    .bus     (bus),
    .nEN     (nEN),
    .lzs     (lzs),
    .seg     (seg),
    .digit_n (digit_n),
    .frame   (frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        lz;
    logic [27:0] segs;   // digit d pattern at [7d +: 7]
    logic [3:0]  lit;
  } vec_t;

  typedef struct {
    int         due;
    logic [3:0] dn;
    logic [6:0] sg;
  } exp_t;

  exp_t sbq[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   t       = 0;   // cycles since last reset release
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0d: got %h expected %h", name, t, act, exp);
  endtask

  // Expected display for output cycles a..b: output at cycle tt reflects
  // scan position of cycle tt-1.
  task automatic push_range(input int a, input int b, input logic [27:0] segs,
                            input logic [3:0] lit, input bit en);
    exp_t       e;
    logic [3:0] one;
    int         sa, d, c;
    bit         on;
    one = 4'b0001;
    for (int tt = a; tt <= b; tt++) begin
      sa    = tt - 1;
      d     = (sa / PRESCALE) % DIGITS;
      c     = sa % PRESCALE;
      on    = en && (c >= BLANK) && lit[d];
      e.due = tt;
      e.dn  = on ? ~(one << d) : 4'hF;
      e.sg  = on ? segs[d*7 +: 7] : 7'h00;
      sbq.push_back(e);
    end
  endtask

  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    t++;
    check("frame", 32'(frame), 32'((t >= 16) && (t % 16 == 0)));
    while (sbq.size() > 0 && sbq[0].due <= t) begin
      e = sbq.pop_front();
      check("scan{seg,digit_n}", 32'({seg, digit_n}), 32'({e.sg, e.dn}));
    end
  endtask

  task automatic go_to(input int target);
    while (t < target) cyc();
  endtask

  task automatic wait_phase(input int p);
    do cyc(); while (t % 16 != p);
  endtask

  task automatic apply_vec(input vec_t v);
    int t0, f;
    wait_phase(2);
    check("ready_idle", 32'(bus.ready), 32'd1);
    bus.data = v.data;
    lzs      = v.lz;
    bus.load = 1'b1;
    t0 = t;
    f  = t0 + 13;
    push_range(f + 2, f + 17, v.segs, v.lit, 1'b1);
    cyc();
    bus.load = 1'b0;
    bus.data = 16'hFFFF;
    check("ready_fall", 32'(bus.ready), 32'd0);
    go_to(f);
    check("ready_pend", 32'(bus.ready), 32'd0);
    cyc();
    check("ready_rise", 32'(bus.ready), 32'd1);
    go_to(f + 17);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg"},     32'(seg),       32'h00);
    check({tag, "_digit_n"}, 32'(digit_n),   32'hF);
    check({tag, "_frame"},   32'(frame),     32'd0);
    check({tag, "_ready"},   32'(bus.ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, t=%0d", t);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, f;

    vecs[0] = '{16'h1234, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'hF};
    vecs[1] = '{16'h0050, 1'b1, {7'h00, 7'h00, 7'h6D, 7'h3F}, 4'h3};
    vecs[2] = '{16'h0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'h1};
    vecs[3] = '{16'h0800, 1'b1, {7'h00, 7'h7F, 7'h3F, 7'h3F}, 4'h7};
    vecs[4] = '{16'h8000, 1'b1, {7'h7F, 7'h3F, 7'h3F, 7'h3F}, 4'hF};
    vecs[5] = '{16'h6789, 1'b0, {7'h7D, 7'h07, 7'h7F, 7'h6F}, 4'hF};
    vecs[6] = '{16'h000F, 1'b1, {7'h00, 7'h00, 7'h00, 7'h71}, 4'h1};
    vecs[7] = '{16'hBCDE, 1'b0, {7'h7C, 7'h39, 7'h5E, 7'h79}, 4'hF};
    vecs[8] = '{16'h0000, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'hF};
    vecs[9] = '{16'h0001, 1'b1, {7'h00, 7'h00, 7'h00, 7'h06}, 4'h1};

    bus.data = '0;
    bus.load = 1'b0;

    // Power-on reset and first frames of an all-zero display
    #2 nRST = 1'b0;
    #1 check_reset_outputs("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    nRST = 1'b1;
    t    = 0;
    push_range(1, 32, {4{7'h3F}}, 4'hF, 1'b1);
    go_to(32);

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Handshake collision: ignored load while pending, load on the frame tick
    wait_phase(2);
    check("coll_idle", 32'(bus.ready), 32'd1);
    lzs      = 1'b0;
    bus.data = 16'hAAAA;
    bus.load = 1'b1;
    t0 = t;
    f  = t0 + 13;
    push_range(f + 2, f + 33, {4{7'h77}}, 4'hF, 1'b1);
    push_range(f + 34, f + 49, {7'h39, 7'h5E, 7'h79, 7'h71}, 4'hF, 1'b1);
    cyc();
    bus.load = 1'b0;
    check("coll_fall", 32'(bus.ready), 32'd0);
    go_to(t0 + 3);
    bus.data = 16'hBBBB;
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    check("coll_ignored", 32'(bus.ready), 32'd0);
    go_to(f);
    check("coll_pend", 32'(bus.ready), 32'd0);
    cyc();
    check("coll_rise", 32'(bus.ready), 32'd1);
    go_to(f + 16);
    bus.data = 16'hCDEF;
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    check("coll_tick_accept", 32'(bus.ready), 32'd0);
    go_to(f + 32);
    check("coll_tick_pend", 32'(bus.ready), 32'd0);
    cyc();
    check("coll_tick_rise", 32'(bus.ready), 32'd1);
    go_to(f + 49);

    // Display disable mid-slot with a commit happening while disabled
    wait_phase(2);
    check("nen_idle", 32'(bus.ready), 32'd1);
    bus.data = 16'h4321;
    bus.load = 1'b1;
    t0 = t;
    f  = t0 + 13;
    push_range(t0 + 1, t0 + 4, {7'h39, 7'h5E, 7'h79, 7'h71}, 4'hF, 1'b1);
    push_range(t0 + 5, f + 7, 28'h0, 4'h0, 1'b0);
    push_range(f + 8, f + 17, {7'h66, 7'h4F, 7'h5B, 7'h06}, 4'hF, 1'b1);
    cyc();
    bus.load = 1'b0;
    check("nen_fall", 32'(bus.ready), 32'd0);
    go_to(t0 + 4);
    nEN = 1'b1;
    go_to(f);
    check("nen_pend", 32'(bus.ready), 32'd0);
    cyc();
    check("nen_commit", 32'(bus.ready), 32'd1);
    go_to(f + 7);
    nEN = 1'b0;
    go_to(f + 17);

    // Reset mid-frame with a value pending
    wait_phase(2);
    bus.data = 16'h5678;
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    check("mrst_pend", 32'(bus.ready), 32'd0);
    wait_phase(8);
    #2 nRST = 1'b0;
    #1 check_reset_outputs("mrst_async");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_outputs("mrst_hold");
    nRST = 1'b1;
    t    = 0;
    push_range(1, 40, {4{7'h3F}}, 4'hF, 1'b1);
    go_to(40);
    check("mrst_ready_after", 32'(bus.ready), 32'd1);

    check("sb_drain", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
